// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive sequencer.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        WAIT_CLR = 2'd2
    } rx_state_t;

    localparam int unsigned OVERSAMPLE = 16;

    // Sticky error flag bit positions
    localparam int unsigned FLAG_PARITY   = 0;
    localparam int unsigned FLAG_FRAMING  = 1;
    localparam int unsigned FLAG_OVERFLOW = 2;
    localparam int unsigned FLAG_TIMEOUT  = 3;
    localparam int unsigned NUM_FLAGS     = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through synchronous FIFO with registered head, flags and occupancy.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_nxt_c;
    logic [CW-1:0]    count_nxt_c;
    logic             push_ok_c;
    logic             pop_ok_c;

    always_comb begin
        push_ok_c   = push & ~full;
        pop_ok_c    = pop & ~empty;
        rd_nxt_c    = rd_ptr + AW'(pop_ok_c);
        count_nxt_c = count + CW'(push_ok_c) - CW'(pop_ok_c);
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= din;
        end
    end

    // Head register looks ahead so it already shows the new head after a pop or first push
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_ok_c);
            rd_ptr <= rd_nxt_c;
            count  <= count_nxt_c;
            empty  <= (count_nxt_c == '0);
            full   <= (count_nxt_c == CW'(DEPTH));
            if (push_ok_c && (wr_ptr == rd_nxt_c)) begin
                dout <= din;
            end else if (count_nxt_c != '0) begin
                dout <= mem[rd_nxt_c];
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: baud tick, receiver drain FSM, FIFO, sticky errors, interrupt.
// Optional idle timeout is built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned BAUD_W     = 13,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned TMO_BITS   = 40
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [BAUD_W-1:0]             baud_val,
    output logic                          baud_en,
    input  logic                          rx_full,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_done,
    input  logic                          rx_parity_err,
    input  logic                          rx_framing_err,
    output logic                          rx_clr,
    output logic                          par_clr,
    input  logic                          host_rd,
    output logic [7:0]                    host_data,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    input  logic                          err_clr,
    output logic                          parity_err,
    output logic                          framing_err,
    output logic                          overflow,
    output logic                          timeout,
    input  logic                          rx_irq_en,
    input  logic                          err_irq_en,
    output logic                          irq
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TMO_BITS == 0) begin : g_bad_params
        $error("uart_rx_ctrl: FIFO_DEPTH must be a power of 2 >= 2 and TMO_BITS nonzero");
    end

    rx_state_t              state;
    rx_state_t              state_nxt;
    logic                   push_c;
    logic                   pop_c;
    logic                   tmo_set_c;
    logic [BAUD_W-1:0]      baud_cnt;
    logic [NUM_FLAGS-1:0]   flags;
    logic [NUM_FLAGS-1:0]   flag_set_c;
    logic [NUM_FLAGS-1:0]   flag_clr_c;

    // Baud down-counter; a new divisor is only picked up on reload
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt <= baud_val;
            baud_en  <= 1'b0;
        end else begin
            baud_en  <= (baud_cnt == '0);
            baud_cnt <= (baud_cnt == '0) ? baud_val : baud_cnt - BAUD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (rx_full && !fifo_full) state_nxt = CAPTURE;
            CAPTURE:  state_nxt = WAIT_CLR;
            WAIT_CLR: if (!rx_full) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        push_c = 1'b0;
        if (state == CAPTURE) begin
            push_c = 1'b1;
        end
    end

    // Strobes registered from the next state so they are high exactly during CAPTURE
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_clr  <= 1'b0;
            par_clr <= 1'b0;
        end else begin
            rx_clr  <= (state_nxt == CAPTURE);
            par_clr <= (state_nxt == CAPTURE) & rx_parity_err;
        end
    end

    assign pop_c = host_rd & ~fifo_empty;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .din   (rx_data),
        .pop   (host_rd),
        .dout  (host_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

`ifdef UART_RX_TIMEOUT_EN
    localparam int unsigned TMO_TICKS = OVERSAMPLE * TMO_BITS;
    localparam int unsigned TMO_W     = $clog2(TMO_TICKS + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_zero_c;

    assign tmo_zero_c = push_c | pop_c | err_clr | fifo_empty;
    assign tmo_set_c  = ~tmo_zero_c & baud_en & (tmo_cnt == TMO_W'(TMO_TICKS - 1));

    // Counts baud ticks while data sits unread; saturates at the limit
    always_ff @(posedge clk) begin
        if (reset || tmo_zero_c) begin
            tmo_cnt <= '0;
        end else if (baud_en && (tmo_cnt != TMO_W'(TMO_TICKS))) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`else
    assign tmo_set_c = 1'b0;
`endif

    // Overflow: a new frame finished while the previous byte is still undrained
    always_comb begin
        flag_set_c                = '0;
        flag_set_c[FLAG_PARITY]   = par_clr;
        flag_set_c[FLAG_FRAMING]  = rx_framing_err;
        flag_set_c[FLAG_OVERFLOW] = rx_done & rx_full & (state != CAPTURE);
        flag_set_c[FLAG_TIMEOUT]  = tmo_set_c;
        flag_clr_c                = {NUM_FLAGS{err_clr}};
        flag_clr_c[FLAG_TIMEOUT]  = err_clr | pop_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= '0;
            irq   <= 1'b0;
        end else begin
            flags <= (flags & ~flag_clr_c) | flag_set_c;
            irq   <= (rx_irq_en & ~fifo_empty) | (err_irq_en & (|flags));
        end
    end

    assign parity_err  = flags[FLAG_PARITY];
    assign framing_err = flags[FLAG_FRAMING];
    assign overflow    = flags[FLAG_OVERFLOW];
    assign timeout     = flags[FLAG_TIMEOUT];

endmodule
